// File: rtl/sgmag_conv_pipe.sv
// Two-stage, multi-channel two's-complement <-> sign-magnitude converter
// with valid/ready backpressure, saturation/negative-zero flags and a
// saturating count of output beats that carried a saturated channel.

// Per-channel conversion, purely combinational; sits between S1 and S2.
module sgmag_lane #(
   parameter int WIDTH = 18
) (
   input  logic             mode,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             sat,
   output logic             nz
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             sign;
   logic             mag_zero;
   logic [WIDTH-1:0] neg_x;
   logic [WIDTH-1:0] neg_m;

   assign sign     = x[WIDTH-1];
   assign mag_zero = (x[WIDTH-2:0] == '0);
   assign neg_x    = ~x + ONE;
   assign neg_m    = ~{1'b0, x[WIDTH-2:0]} + ONE;

   // Non-negative words pass through unchanged in either direction; only
   // sign=1 words need work, and the all-zero magnitude is the corner case.
   always_comb begin
      y   = x;
      sat = 1'b0;
      nz  = 1'b0;
      if (sign) begin
         if (!mode) begin
            if (mag_zero) begin
               // -2^(W-1) has no sign-mag encoding: clamp to largest magnitude
               y   = {1'b1, {(WIDTH-1){1'b1}}};
               sat = 1'b1;
            end else begin
               y = {1'b1, neg_x[WIDTH-2:0]};
            end
         end else begin
            if (mag_zero) begin
               y  = '0;
               nz = 1'b1;
            end else begin
               y = neg_m;
            end
         end
      end
   end
endmodule

module sgmag_conv_pipe #(
   parameter int WIDTH = 18,
   parameter int NCH   = 2,
   parameter int CNTW  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [NCH*WIDTH-1:0]  in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NCH*WIDTH-1:0]  out_data,
   output logic [NCH-1:0]        out_sat,
   output logic [NCH-1:0]        out_nz,
   output logic                  out_mode,
   output logic [CNTW-1:0]       sat_cnt,
   input  logic                  cnt_clr
);
   // vld_pipe[0] = S1 occupied, vld_pipe[1] = S2 occupied
   logic [1:0]                  vld_pipe;
   logic                        s1_load;
   logic                        s2_load;
   logic [NCH-1:0][WIDTH-1:0]   s1_data;
   logic                        s1_mode;
   logic [NCH-1:0][WIDTH-1:0]   cv_data;
   logic [NCH-1:0]              cv_sat;
   logic [NCH-1:0]              cv_nz;

   assign s2_load   = !vld_pipe[1] || out_ready;
   assign s1_load   = !vld_pipe[0] || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = vld_pipe[1];

   genvar k;
   generate
      for (k = 0; k < NCH; k++) begin : g_lane
         sgmag_lane #(.WIDTH(WIDTH)) u_lane (
            .mode (s1_mode),
            .x    (s1_data[k]),
            .y    (cv_data[k]),
            .sat  (cv_sat[k]),
            .nz   (cv_nz[k])
         );
      end
   endgenerate

   // S1: capture raw beat and its mode when the stage can advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe[0] <= 1'b0;
         s1_data     <= '0;
         s1_mode     <= 1'b0;
      end else if (s1_load) begin
         vld_pipe[0] <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_mode <= in_mode;
         end
      end
   end

   // S2: register converted results; held untouched while stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe[1] <= 1'b0;
         out_data    <= '0;
         out_sat     <= '0;
         out_nz      <= '0;
         out_mode    <= 1'b0;
      end else if (s2_load) begin
         vld_pipe[1] <= vld_pipe[0];
         if (vld_pipe[0]) begin
            out_data <= cv_data;
            out_sat  <= cv_sat;
            out_nz   <= cv_nz;
            out_mode <= s1_mode;
         end
      end
   end

   // Count delivered beats with any saturated channel; clear has priority
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sat_cnt <= '0;
      else if (cnt_clr)
         sat_cnt <= '0;
      else if (out_valid && out_ready && (|out_sat) && (sat_cnt != {CNTW{1'b1}}))
         sat_cnt <= sat_cnt + CNTW'(1);
   end
endmodule

// File: tb/tb_sgmag_conv_pipe.sv
// Directed bench for sgmag_conv_pipe (WIDTH=18, NCH=2, CNTW=2).
module tb_sgmag_conv_pipe;
   localparam int WIDTH = 18;
   localparam int NCH   = 2;
   localparam int CNTW  = 2;

   logic                 clk;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_mode;
   logic [NCH*WIDTH-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [NCH*WIDTH-1:0] out_data;
   logic [NCH-1:0]       out_sat;
   logic [NCH-1:0]       out_nz;
   logic                 out_mode;
   logic [CNTW-1:0]      sat_cnt;
   logic                 cnt_clr;

   int n_checks = 0;
   int n_errors = 0;

   sgmag_conv_pipe #(.WIDTH(WIDTH), .NCH(NCH), .CNTW(CNTW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_nz    (out_nz),
      .out_mode  (out_mode),
      .sat_cnt   (sat_cnt),
      .cnt_clr   (cnt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one beat for a single cycle; caller ensures in_ready is high.
   task automatic send_beat(input logic mode, input logic [NCH*WIDTH-1:0] data);
      in_mode  = mode;
      in_data  = data;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_data !== 36'h0) begin n_errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_checks++; if ({out_sat, out_nz, out_mode} !== 5'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 0", {out_sat, out_nz, out_mode}); end
      n_checks++; if (sat_cnt !== 2'd0) begin n_errors++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_mode0();
      send_beat(1'b0, {18'h3FFFF, 18'h00064});
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL m0_latency1: out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL m0_latency2: out_valid got %b want 1", out_valid); end
      n_checks++; if (out_data !== {18'h20001, 18'h00064}) begin n_errors++; $display("FAIL m0_data: got %h want %h", out_data, {18'h20001, 18'h00064}); end
      n_checks++; if ({out_sat, out_nz, out_mode} !== 5'b0) begin n_errors++; $display("FAIL m0_flags: got %b want 00000", {out_sat, out_nz, out_mode}); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL m0_single: out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_saturate();
      send_beat(1'b0, {18'h20001, 18'h20000});
      @(posedge clk); #1;
      n_checks++; if (out_data !== {18'h3FFFF, 18'h3FFFF}) begin n_errors++; $display("FAIL sat_data: got %h want %h", out_data, {18'h3FFFF, 18'h3FFFF}); end
      n_checks++; if (out_sat !== 2'b01) begin n_errors++; $display("FAIL sat_flags: got %b want 01", out_sat); end
      n_checks++; if (sat_cnt !== 2'd0) begin n_errors++; $display("FAIL sat_cnt_before: got %0d want 0", sat_cnt); end
      @(posedge clk); #1;
      n_checks++; if (sat_cnt !== 2'd1) begin n_errors++; $display("FAIL sat_cnt_after: got %0d want 1", sat_cnt); end
   endtask

   task automatic test_mode1();
      send_beat(1'b1, {18'h20005, 18'h20000});
      @(posedge clk); #1;
      n_checks++; if (out_data !== {18'h3FFFB, 18'h00000}) begin n_errors++; $display("FAIL m1_data: got %h want %h", out_data, {18'h3FFFB, 18'h00000}); end
      n_checks++; if (out_nz !== 2'b01) begin n_errors++; $display("FAIL m1_nz: got %b want 01", out_nz); end
      n_checks++; if (out_sat !== 2'b00) begin n_errors++; $display("FAIL m1_sat: got %b want 00", out_sat); end
      n_checks++; if (out_mode !== 1'b1) begin n_errors++; $display("FAIL m1_mode: got %b want 1", out_mode); end
      // round trip: -5 back to sign-mag; plus max positive pass-through
      send_beat(1'b0, {18'h1FFFF, 18'h3FFFB});
      @(posedge clk); #1;
      n_checks++; if (out_data !== {18'h1FFFF, 18'h20005}) begin n_errors++; $display("FAIL roundtrip_data: got %h want %h", out_data, {18'h1FFFF, 18'h20005}); end
      n_checks++; if ({out_nz, out_mode} !== 3'b000) begin n_errors++; $display("FAIL roundtrip_flags: got %b want 000", {out_nz, out_mode}); end
      // mode 1 positive words pass through
      send_beat(1'b1, {18'h00007, 18'h1FFFF});
      @(posedge clk); #1;
      n_checks++; if (out_data !== {18'h00007, 18'h1FFFF}) begin n_errors++; $display("FAIL m1_pos_data: got %h want %h", out_data, {18'h00007, 18'h1FFFF}); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [17:0] in_ch1  [10] = '{18'h3FFFE, 18'h20003, 18'h3FFFD, 18'h20002, 18'h3FFFC,
                                    18'h20001, 18'h3FFFB, 18'h20004, 18'h3FFF0, 18'h20010};
      logic [17:0] exp_ch1 [10] = '{18'h20002, 18'h3FFFD, 18'h20003, 18'h3FFFE, 18'h20004,
                                    18'h3FFFF, 18'h20005, 18'h3FFFC, 18'h20010, 18'h3FFF0};
      logic [3:0]  pat = 4'b1001;   // out_ready sequence 1,0,0,1 (bit 0 first)
      int sent = 0;
      int rcv  = 0;
      int occ  = 0;
      logic held = 1'b0;
      logic [NCH*WIDTH+2*NCH:0] held_val = '0;
      logic acc, fire, exp_rdy;
      for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
         out_ready = pat[cyc % 4];
         in_valid  = (sent < 10);
         if (sent < 10) begin
            in_mode = sent[0];
            in_data = {in_ch1[sent], 18'h00010 + 18'(sent)};
         end
         #1;
         exp_rdy = (occ < 2) || out_ready;
         n_checks++; if (in_ready !== exp_rdy) begin n_errors++; $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy); end
         if (held) begin
            n_checks++;
            if (out_valid !== 1'b1 || {out_data, out_sat, out_nz, out_mode} !== held_val) begin
               n_errors++; $display("FAIL bp_stall_hold cyc %0d: got %b/%h want 1/%h", cyc, out_valid, {out_data, out_sat, out_nz, out_mode}, held_val);
            end
         end
         acc  = in_valid && in_ready;
         fire = out_valid && out_ready;
         if (fire) begin
            n_checks++;
            if (out_data !== {exp_ch1[rcv], 18'h00010 + 18'(rcv)} || out_mode !== rcv[0] || {out_sat, out_nz} !== 4'b0) begin
               n_errors++; $display("FAIL bp_beat %0d: got %h mode %b flags %b want %h mode %b flags 0000",
                                    rcv, out_data, out_mode, {out_sat, out_nz}, {exp_ch1[rcv], 18'h00010 + 18'(rcv)}, rcv[0]);
            end
            rcv++;
         end
         held     = out_valid && !out_ready;
         held_val = {out_data, out_sat, out_nz, out_mode};
         @(posedge clk); #1;
         occ  = occ + int'(acc) - int'(fire);
         sent = sent + int'(acc);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_checks++; if (rcv !== 10) begin n_errors++; $display("FAIL bp_count: got %0d beats want 10", rcv); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_no_extra: out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_sat_counter();
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      n_checks++; if (sat_cnt !== 2'd0) begin n_errors++; $display("FAIL cnt_clear: got %0d want 0", sat_cnt); end
      for (int i = 0; i < 5; i++) begin
         in_mode  = 1'b0;
         in_data  = {18'h00001, 18'h20000};
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (sat_cnt !== 2'd3) begin n_errors++; $display("FAIL cnt_stick: got %0d want 3", sat_cnt); end
      send_beat(1'b0, {18'h20000, 18'h00000});
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_sat !== 2'b10) begin n_errors++; $display("FAIL cnt_6th_beat: valid/sat got %b/%b want 1/10", out_valid, out_sat); end
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      n_checks++; if (sat_cnt !== 2'd0) begin n_errors++; $display("FAIL cnt_clr_wins: got %0d want 0", sat_cnt); end
   endtask

   task automatic test_reset_midstream();
      send_beat(1'b0, {18'h00000, 18'h20000});
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (sat_cnt !== 2'd1) begin n_errors++; $display("FAIL rst_pre_cnt: got %0d want 1", sat_cnt); end
      out_ready = 1'b0;
      in_mode   = 1'b0;
      in_data   = {18'h00000, 18'h20000};
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_data   = {18'h00005, 18'h00006};
      @(posedge clk); #1;
      in_valid  = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rst_inflight: out_valid got %b want 1", out_valid); end
      reset = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
      n_checks++; if (sat_cnt !== 2'd0) begin n_errors++; $display("FAIL rst_async_cnt: got %0d want 0", sat_cnt); end
      n_checks++; if ({out_data, out_sat, out_nz} !== 40'h0) begin n_errors++; $display("FAIL rst_async_data: got %h want 0", {out_data, out_sat, out_nz}); end
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_no_stale: out_valid got %b want 0", out_valid); end
      send_beat(1'b0, {18'h00000, 18'h3FFFF});
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_new_lat1: out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== {18'h00000, 18'h20001}) begin n_errors++; $display("FAIL rst_new_beat: got %b/%h want 1/%h", out_valid, out_data, {18'h00000, 18'h20001}); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_new_single: out_valid got %b want 0", out_valid); end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      test_reset();
      test_mode0();
      test_saturate();
      test_mode1();
      test_back_to_back();
      test_sat_counter();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
